// File: rtl/ifu_exu_ibuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_exu_ibuf_pkg
// Description : Shared sizing constants and helpers for the IFU->EXU
//               instruction buffer (widths, default depth, predecode and
//               saturating-counter helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_exu_ibuf_pkg;

    // Default widths and depth of the buffer.
    localparam int IBUF_PC_SIZE = 32;
    localparam int IBUF_XLEN    = 32;
    localparam int IBUF_DEPTH   = 2;

    // Width of the optional performance counters.
    localparam int IBUF_CNT_W   = 32;

    typedef logic [IBUF_CNT_W-1:0] ibuf_cnt_t;

    // A 32-bit RISC-V encoding has both low opcode bits set; anything else
    // is a 16-bit compressed instruction.
    function automatic logic ibuf_is_rv32(input logic [1:0] ir_lo);
        return (ir_lo == 2'b11);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic ibuf_cnt_t ibuf_sat_inc(input ibuf_cnt_t val, input logic en);
        if (en && (val != {IBUF_CNT_W{1'b1}})) begin
            return val + ibuf_cnt_t'(1);
        end
        return val;
    endfunction

endpackage : ifu_exu_ibuf_pkg
`default_nettype wire

// File: rtl/ibuf_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ibuf_fifo_ptr
// Description : Read/write pointer pair for the instruction buffer FIFO.
//               Pointers carry one extra wrap bit so that full and empty are
//               distinguished purely from registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module ibuf_fifo_ptr #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH)-1:0]   waddr_o,
    output logic [$clog2(DEPTH)-1:0]   raddr_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    logic [c_PW-1:0] wptr_q;
    logic [c_PW-1:0] wptr_d;
    logic [c_PW-1:0] rptr_q;
    logic [c_PW-1:0] rptr_d;
    logic [c_PW-1:0] count;

    // Next pointer values: flush wins over any push/pop in the same cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) begin
                wptr_d = wptr_q + c_PW'(1);
            end
            if (pop_i) begin
                rptr_d = rptr_q + c_PW'(1);
            end
        end
    end

    // Pointer registers; they roll over naturally through the wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign count   = wptr_q - rptr_q;
    assign full_o  = (count == c_PW'(DEPTH));
    assign empty_o = (count == '0);
    assign waddr_o = wptr_q[c_AW-1:0];
    assign raddr_o = rptr_q[c_AW-1:0];

endmodule : ibuf_fifo_ptr
`default_nettype wire

// File: rtl/ifu_exu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : ifu_exu_ibuf
// Description : Instruction buffer between IFU and EXU. Holds DEPTH {IR, PC}
//               pairs, presents the oldest with an rv32 predecode flag, keeps
//               the IFU ready path purely registered and drops everything on
//               a pipe flush.
//               Optional build macro IBUF_PERF_CNT_EN adds saturating stall
//               and bubble cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_exu_ibuf
    import ifu_exu_ibuf_pkg::*;
#(
    parameter int PC_SIZE = IBUF_PC_SIZE,
    parameter int XLEN    = IBUF_XLEN,
    parameter int DEPTH   = IBUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ibuf_i_ifu_valid,
    output logic                 ibuf_o_ifu_ready,
    input  logic [XLEN-1:0]      ibuf_i_ir,
    input  logic [PC_SIZE-1:0]   ibuf_i_pc,
    output logic                 ibuf_o_exu_valid,
    input  logic                 ibuf_i_exu_ready,
    output logic [XLEN-1:0]      ibuf_o_ir,
    output logic [PC_SIZE-1:0]   ibuf_o_pc,
    output logic                 ibuf_o_rv32,
    input  logic                 ibuf_i_flush_req,
`ifdef IBUF_PERF_CNT_EN
    output logic [31:0]          ibuf_o_stall_cnt,
    output logic [31:0]          ibuf_o_bubble_cnt,
`endif
    output logic                 ibuf_o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [c_AW-1:0]   waddr;
    logic [c_AW-1:0]   raddr;
    logic [XLEN-1:0]   ir_q [DEPTH];
    logic [PC_SIZE-1:0] pc_q [DEPTH];
    logic [XLEN-1:0]   head_ir;

    // Handshakes; a flush swallows both the incoming beat and the head pop.
    assign ibuf_o_ifu_ready = ~full;
    assign ibuf_o_exu_valid = ~empty;
    assign push = ibuf_i_ifu_valid & ~full  & ~ibuf_i_flush_req;
    assign pop  = ~empty & ibuf_i_exu_ready & ~ibuf_i_flush_req;

    ibuf_fifo_ptr #(
        .DEPTH   (DEPTH)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (ibuf_i_flush_req),
        .waddr_o (waddr),
        .raddr_o (raddr),
        .full_o  (full),
        .empty_o (empty)
    );

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            // Entry storage; cleared on reset so outputs are never X.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ir_q[i] <= '0;
                    pc_q[i] <= '0;
                end else if (push && (waddr == c_AW'(i))) begin
                    ir_q[i] <= ibuf_i_ir;
                    pc_q[i] <= ibuf_i_pc;
                end
            end
        end
    endgenerate

    // Head entry straight from storage: no bypass from the IFU inputs.
    assign head_ir      = ir_q[raddr];
    assign ibuf_o_ir    = head_ir;
    assign ibuf_o_pc    = pc_q[raddr];
    assign ibuf_o_rv32  = ibuf_is_rv32(head_ir[1:0]);
    assign ibuf_o_empty = empty;

`ifdef IBUF_PERF_CNT_EN
    ibuf_cnt_t stall_cnt_q;
    ibuf_cnt_t stall_cnt_d;
    ibuf_cnt_t bubble_cnt_q;
    ibuf_cnt_t bubble_cnt_d;

    // Stall: IFU offers but we are full. Bubble: nothing for EXU, except the
    // flush cycle itself. Flush does not clear these.
    always_comb begin
        stall_cnt_d  = ibuf_sat_inc(stall_cnt_q,  ibuf_i_ifu_valid & full);
        bubble_cnt_d = ibuf_sat_inc(bubble_cnt_q, empty & ~ibuf_i_flush_req);
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ibuf_o_stall_cnt  = stall_cnt_q;
    assign ibuf_o_bubble_cnt = bubble_cnt_q;
`endif

endmodule : ifu_exu_ibuf
`default_nettype wire

// File: tb/tb_ifu_exu_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_exu_ibuf
// Description : Self-checking bench for ifu_exu_ibuf: a queue-based model
//               checked every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_exu_ibuf;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        ifu_valid;
    logic        ifu_ready;
    logic [31:0] ir_in;
    logic [31:0] pc_in;
    logic        exu_valid;
    logic        exu_ready;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        rv32;
    logic        flush;
    logic        empty;
`ifdef IBUF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
    logic [31:0] m_stall;
    logic [31:0] m_bubble;
    logic [31:0] snap;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    ifu_exu_ibuf #(
        .PC_SIZE           (32),
        .XLEN              (32),
        .DEPTH             (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ibuf_i_ifu_valid  (ifu_valid),
        .ibuf_o_ifu_ready  (ifu_ready),
        .ibuf_i_ir         (ir_in),
        .ibuf_i_pc         (pc_in),
        .ibuf_o_exu_valid  (exu_valid),
        .ibuf_i_exu_ready  (exu_ready),
        .ibuf_o_ir         (ir_out),
        .ibuf_o_pc         (pc_out),
        .ibuf_o_rv32       (rv32),
        .ibuf_i_flush_req  (flush),
`ifdef IBUF_PERF_CNT_EN
        .ibuf_o_stall_cnt  (stall_cnt),
        .ibuf_o_bubble_cnt (bubble_cnt),
`endif
        .ibuf_o_empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a bounded queue. Decisions use the occupancy before the edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
`ifdef IBUF_PERF_CNT_EN
            m_stall  = 0;
            m_bubble = 0;
`endif
        end else begin
`ifdef IBUF_PERF_CNT_EN
            if (ifu_valid && q.size() == DEPTH && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (q.size() == 0 && !flush && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
            if (flush) begin
                q.delete();
            end else begin
                logic can_push;
                can_push = ifu_valid && (q.size() < DEPTH);
                if (q.size() > 0 && exu_ready) void'(q.pop_front());
                if (can_push) q.push_back('{ir: ir_in, pc: pc_in});
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", {31'd0, ifu_ready}, 32'd1);
            chk("rst_valid", {31'd0, exu_valid}, 32'd0);
            chk("rst_empty", {31'd0, empty},     32'd1);
            chk("rst_ir",    ir_out,             32'd0);
            chk("rst_pc",    pc_out,             32'd0);
            chk("rst_rv32",  {31'd0, rv32},      32'd0);
        end else begin
            chk("m_ready", {31'd0, ifu_ready}, {31'd0, q.size() < DEPTH});
            chk("m_valid", {31'd0, exu_valid}, {31'd0, q.size() > 0});
            chk("m_empty", {31'd0, empty},     {31'd0, q.size() == 0});
            if (q.size() > 0) begin
                chk("m_ir",   ir_out,         q[0].ir);
                chk("m_pc",   pc_out,         q[0].pc);
                chk("m_rv32", {31'd0, rv32},  {31'd0, q[0].ir[1:0] == 2'b11});
            end
`ifdef IBUF_PERF_CNT_EN
            chk("m_stall",  stall_cnt,  m_stall);
            chk("m_bubble", bubble_cnt, m_bubble);
`endif
        end
    end

    // One cycle of stimulus; returns 1 time unit after the edge.
    task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                        input logic er, input logic fl);
        ifu_valid = v;
        ir_in     = ir;
        pc_in     = pc;
        exu_ready = er;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ifu_valid = 1'b0;
        ir_in     = '0;
        pc_in     = '0;
        exu_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ifu_ready}, 32'd1);
        chk("reset_valid", {31'd0, exu_valid}, 32'd0);
        chk("reset_empty", {31'd0, empty},     32'd1);
        rst = 1'b0;

        // Reset then single push
        step(1'b1, 32'h0000_0013, 32'h8000_0000, 1'b0, 1'b0);
        chk("push1_valid", {31'd0, exu_valid}, 32'd1);
        chk("push1_ir",    ir_out,             32'h0000_0013);
        chk("push1_pc",    pc_out,             32'h8000_0000);
        chk("push1_rv32",  {31'd0, rv32},      32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pop1_empty",  {31'd0, empty},     32'd1);

        // Fill to full with EXU stalled
        step(1'b1, 32'h0000_0093, 32'h0000_0000, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0113, 32'h0000_0004, 1'b0, 1'b0);
        chk("full_ready", {31'd0, ifu_ready}, 32'd0);
        chk("full_pc",    pc_out,             32'h0000_0000);
        step(1'b1, 32'h0020_0193, 32'h0000_0008, 1'b0, 1'b0);
        chk("full_hold_pc",    pc_out,             32'h0000_0000);
        chk("full_hold_ready", {31'd0, ifu_ready}, 32'd0);
        // Full with pop: beat still refused this cycle, ready back next
        step(1'b1, 32'h0020_0193, 32'h0000_0008, 1'b1, 1'b0);
        chk("fullpop_ready", {31'd0, ifu_ready}, 32'd1);
        chk("fullpop_pc",    pc_out,             32'h0000_0004);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Streaming: one per cycle, occupancy stays at one
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h0000_0013 + (k << 20), k * 4, 1'b1, 1'b0);
            chk("stream_pc",    pc_out,             k * 4);
            chk("stream_ready", {31'd0, ifu_ready}, 32'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_empty", {31'd0, empty}, 32'd1);

        // Flush with both entries full
        step(1'b1, 32'h0000_0013, 32'h0000_0040, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h0000_0044, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h0000_0100, 1'b0, 1'b1);
        chk("flush_empty", {31'd0, empty},     32'd1);
        chk("flush_valid", {31'd0, exu_valid}, 32'd0);
        chk("flush_ready", {31'd0, ifu_ready}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_dropped", {31'd0, exu_valid}, 32'd0);

        // Compressed predecode
        step(1'b1, 32'h0000_4501, 32'h0000_0200, 1'b0, 1'b0);
        chk("c_valid", {31'd0, exu_valid}, 32'd1);
        chk("c_ir",    ir_out,             32'h0000_4501);
        chk("c_rv32",  {31'd0, rv32},      32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef IBUF_PERF_CNT_EN
        step(1'b1, 32'h0000_0013, 32'h0000_0300, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h0000_0304, 1'b0, 1'b0);
        snap = stall_cnt;
        repeat (5) step(1'b1, 32'h0000_0013, 32'h0000_0308, 1'b0, 1'b0);
        chk("stall_delta", stall_cnt - snap, 32'd5);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        snap = bubble_cnt;
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("bubble_delta", bubble_cnt - snap, 32'd3);
`endif

        // Mid-operation reset
        step(1'b1, 32'h0000_0013, 32'h0000_0400, 1'b0, 1'b0);
        chk("pre_rst_pc", pc_out, 32'h0000_0400);
        ifu_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_pc",    pc_out,         32'd0);
        chk("mid_rst_ir",    ir_out,         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_valid", {31'd0, exu_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifu_exu_ibuf
`default_nettype wire
